// File: rtl/pulse_burst_sched_pkg.sv
// Shared types and default constants for the pulse burst scheduler.
package pulse_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COUNT,
    DONE,
    ERR,
    GAP
  } sched_state_t;

  localparam int NREQ_DEF    = 4;
  localparam int PULSES_DEF  = 5;
  localparam int TIMEOUT_DEF = 24;
  localparam int GAP_DEF     = 2;

  // Larger of two elaboration-time integers, used to size shared counters.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_burst_sched_if.sv
// Request/grant and generator-side signals of the pulse burst scheduler.
// master = requesting agents plus generator, slave = the scheduler itself.
interface pulse_burst_sched_if import pulse_sched_pkg::*; #(
  parameter int NREQ = NREQ_DEF
) ();

  localparam int IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  done;
  logic [NREQ-1:0]  err;
  logic             gen_load;
  logic             gen_k;
  logic             busy;
  logic [IDX_W-1:0] active_id;

  modport master (
    output req,
    output gen_k,
    input  grant,
    input  done,
    input  err,
    input  gen_load,
    input  busy,
    input  active_id
  );

  modport slave (
    input  req,
    input  gen_k,
    output grant,
    output done,
    output err,
    output gen_load,
    output busy,
    output active_id
  );

endinterface

// File: rtl/pulse_burst_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping past the top index back to 0.
module rr_arbiter import pulse_sched_pkg::*; #(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             found;
  logic [IDX_W-1:0] pos;

  // Scan NREQ positions starting at the pointer; the first hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = IDX_W'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[pos]) begin
        found        = 1'b1;
        grant_o[pos] = 1'b1;
        idx_o        = pos;
      end
    end
  end

endmodule

// File: rtl/pulse_burst_sched.sv
// Pulse burst scheduler: round-robin access to a shared serial-load pulse
// generator. One owner at a time gets a single-cycle load strobe, then the
// generator's rising edges are counted to completion (done) or timeout (err),
// followed by an enforced idle gap.
module pulse_burst_sched #(
  parameter int NREQ    = pulse_sched_pkg::NREQ_DEF,
  parameter int PULSES  = pulse_sched_pkg::PULSES_DEF,
  parameter int TIMEOUT = pulse_sched_pkg::TIMEOUT_DEF,
  parameter int GAP     = pulse_sched_pkg::GAP_DEF
) (
  input logic                CLK,
  input logic                reset,
  pulse_burst_sched_if.slave bus
);
  // Imported in the body: the GAP parameter shadows the GAP state literal,
  // which is therefore always written package-qualified below.
  import pulse_sched_pkg::*;

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(PULSES + 1);
  // The timer also paces the post-burst gap, so it must hold both limits.
  localparam int TMR_W = $clog2(max_int(TIMEOUT, GAP) + 1);

  sched_state_t     state_q;
  logic [NREQ-1:0]  grant_q;
  logic [NREQ-1:0]  done_q;
  logic [NREQ-1:0]  err_q;
  logic             gen_load_q;
  logic             busy_q;
  logic             k_q;
  logic [IDX_W-1:0] id_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_d;
  logic [NREQ-1:0]  win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             k_rise;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .grant_o (win_oh),
    .idx_o   (win_idx)
  );

  // Next values for the edge counter, timer and round-robin pointer.
  always_comb begin
    k_rise = bus.gen_k & ~k_q;
    cnt_d  = cnt_q + CNT_W'(k_rise);
    tmr_d  = tmr_q + TMR_W'(1);
    ptr_d  = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
  end

  // Burst FSM with registered outputs; done wins over a same-cycle timeout.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= '0;
      gen_load_q <= 1'b0;
      busy_q     <= 1'b0;
      k_q        <= 1'b0;
      id_q       <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
    end else begin
      done_q     <= '0;
      err_q      <= '0;
      gen_load_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|bus.req) begin
            state_q    <= LOAD;
            grant_q    <= win_oh;
            gen_load_q <= 1'b1;
            busy_q     <= 1'b1;
            id_q       <= win_idx;
            ptr_q      <= ptr_d;
          end
        end
        LOAD: begin
          cnt_q   <= '0;
          tmr_q   <= '0;
          k_q     <= 1'b0;
          state_q <= COUNT;
        end
        COUNT: begin
          k_q   <= bus.gen_k;
          cnt_q <= cnt_d;
          tmr_q <= tmr_d;
          if (cnt_d == CNT_W'(PULSES)) begin
            state_q <= DONE;
            done_q  <= grant_q;
          end else if (tmr_d == TMR_W'(TIMEOUT)) begin
            state_q <= ERR;
            err_q   <= grant_q;
          end
        end
        DONE, ERR: begin
          grant_q <= '0;
          tmr_q   <= '0;
          if (GAP == 0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            id_q    <= '0;
          end else begin
            state_q <= pulse_sched_pkg::GAP;
          end
        end
        pulse_sched_pkg::GAP: begin
          tmr_q <= tmr_d;
          if (tmr_d == TMR_W'(GAP)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            id_q    <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.gen_load  = gen_load_q;
  assign bus.busy      = busy_q;
  assign bus.active_id = id_q;

endmodule

// File: tb/tb_pulse_burst_sched.sv
// Bench for pulse_burst_sched: burst-timeline reference model, per-cycle
// comparison, and directed scenarios with hand-computed expectations.
module tb_pulse_burst_sched;

  localparam int NREQ    = 4;
  localparam int PULSES  = 5;
  localparam int TIMEOUT = 24;
  localparam int GAP     = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pulse_burst_sched_if #(.NREQ(NREQ)) bus ();

  pulse_burst_sched #(
    .NREQ    (NREQ),
    .PULSES  (PULSES),
    .TIMEOUT (TIMEOUT),
    .GAP     (GAP)
  ) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Generator stand-in: replays gen_pat bit i on the i-th falling edge after a load strobe.
  logic [31:0] gen_pat = '0;
  int          gidx    = 32;
  always @(negedge clk) begin
    if (bus.gen_load === 1'b1) gidx = 0;
    if (gidx < 32) begin
      bus.gen_k = gen_pat[gidx];
      gidx++;
    end else begin
      bus.gen_k = 1'b0;
    end
  end

  // Reference model: each burst is a timeline anchored at its grant edge L and finish edge F.
  int              m_cyc, m_L, m_fin, m_edges, m_owner, m_ptr, m_idx;
  bit              m_inb, m_fink, m_iserr, m_kprev, m_found;
  logic [NREQ-1:0] e_grant, e_done, e_err;
  logic            e_load, e_busy;
  logic [1:0]      e_id;
  logic [NREQ-1:0] one_hot_base = 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cyc = 0; m_L = 0; m_fin = 0; m_edges = 0; m_owner = 0; m_ptr = 0;
      m_inb = 0; m_fink = 0; m_iserr = 0; m_kprev = 0;
      e_grant = '0; e_done = '0; e_err = '0; e_load = 0; e_busy = 0; e_id = '0;
    end else begin
      m_cyc++;
      // Edge counting starts the cycle after the load cycle.
      if (m_inb && !m_fink && m_cyc >= m_L + 1) begin
        if (m_cyc == m_L + 1) begin
          m_kprev = 0;
        end else begin
          if (bus.gen_k && !m_kprev) m_edges++;
          m_kprev = bus.gen_k;
          if (m_edges == PULSES) begin
            m_fin = m_cyc; m_fink = 1; m_iserr = 0;
          end else if (m_cyc - m_L - 1 == TIMEOUT) begin
            m_fin = m_cyc; m_fink = 1; m_iserr = 1;
          end
        end
      end
      // Requests are only looked at once the previous burst and its gap are over.
      if ((!m_inb || (m_fink && m_cyc > m_fin + 1 + GAP)) && (|bus.req)) begin
        m_found = 0;
        for (int k = 0; k < NREQ; k++) begin
          m_idx = (m_ptr + k) % NREQ;
          if (!m_found && bus.req[m_idx]) begin
            m_found = 1;
            m_owner = m_idx;
          end
        end
        m_ptr   = (m_owner + 1) % NREQ;
        m_inb   = 1;
        m_L     = m_cyc;
        m_fink  = 0;
        m_edges = 0;
      end
      e_grant = (m_inb && (!m_fink || m_cyc <= m_fin)) ? (one_hot_base << m_owner) : '0;
      e_load  = m_inb && (m_cyc == m_L);
      e_done  = (m_inb && m_fink && m_cyc == m_fin && !m_iserr) ? (one_hot_base << m_owner) : '0;
      e_err   = (m_inb && m_fink && m_cyc == m_fin && m_iserr) ? (one_hot_base << m_owner) : '0;
      e_busy  = m_inb && (!m_fink || m_cyc <= m_fin + GAP);
      e_id    = e_busy ? 2'(m_owner) : 2'd0;
    end
  end

  // Every cycle, just after the edge, the DUT must match the model.
  always @(posedge clk) begin
    #1;
    check("cyc_grant",    32'(bus.grant),     32'(e_grant));
    check("cyc_done",     32'(bus.done),      32'(e_done));
    check("cyc_err",      32'(bus.err),       32'(e_err));
    check("cyc_gen_load", 32'(bus.gen_load),  32'(e_load));
    check("cyc_busy",     32'(bus.busy),      32'(e_busy));
    check("cyc_id",       32'(bus.active_id), 32'(e_id));
  end

  // which=0: wait for gen_load; which=1: wait for any done/err. cyc = cycles waited.
  task automatic wait_evt(input int which, input int budget, input string name, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if ((which == 0 && bus.gen_load === 1'b1) ||
          (which == 1 && ((|bus.done) || (|bus.err)))) begin
        cyc = i;
        break;
      end
    end
    if (cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no event within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int              c;
    logic [NREQ-1:0] g;
    reset   = 1'b0;
    bus.req = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant",    32'(bus.grant),     0);
    check("rst_done",     32'(bus.done),      0);
    check("rst_err",      32'(bus.err),       0);
    check("rst_gen_load", 32'(bus.gen_load),  0);
    check("rst_busy",     32'(bus.busy),      0);
    check("rst_id",       32'(bus.active_id), 0);
    @(negedge clk) reset = 1'b1;

    // Single requester 2, alternating generator: 5th edge 10 cycles after grant.
    gen_pat = 32'h0000_2AAA;
    @(negedge clk) bus.req = 4'b0100;
    @(posedge clk); #1;
    check("t1_grant", 32'(bus.grant), 4'b0100);
    check("t1_load",  32'(bus.gen_load), 1);
    check("t1_id",    32'(bus.active_id), 2);
    check("t1_busy",  32'(bus.busy), 1);
    @(posedge clk); #1;
    check("t1_load_drop", 32'(bus.gen_load), 0);
    check("t1_grant_hold", 32'(bus.grant), 4'b0100);
    repeat (8) @(posedge clk);
    #1;
    check("t1_no_early_done", 32'(bus.done), 0);
    @(posedge clk); #1;
    check("t1_done", 32'(bus.done), 4'b0100);
    @(negedge clk) bus.req = '0;
    @(posedge clk); #1;
    check("t1_done_pulse", 32'(bus.done), 0);
    check("t1_grant_drop", 32'(bus.grant), 0);
    check("t1_gap_busy1", 32'(bus.busy), 1);
    @(posedge clk); #1;
    check("t1_gap_busy2", 32'(bus.busy), 1);
    @(posedge clk); #1;
    check("t1_idle_busy", 32'(bus.busy), 0);
    check("t1_idle_id", 32'(bus.active_id), 0);

    // All four requesting: strict rotation 0,1,2,3,0 from a fresh pointer.
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      g = 4'b0001 << (i % 4);
      wait_evt(0, 40, "t2_load_wait", c);
      check("t2_grant", 32'(bus.grant), 32'(g));
      wait_evt(1, 40, "t2_done_wait", c);
      check("t2_done", 32'(bus.done), 32'(g));
      check("t2_err", 32'(bus.err), 0);
    end
    @(negedge clk) bus.req = '0;

    // Generator silent: err exactly 24 cycles into counting (25 after the grant).
    gen_pat = 32'h0;
    @(negedge clk) bus.req = 4'b0001;
    wait_evt(0, 40, "t3_load_wait", c);
    check("t3_grant", 32'(bus.grant), 4'b0001);
    wait_evt(1, 40, "t3_end_wait", c);
    check("t3_err_latency", 32'(c), 25);
    check("t3_err", 32'(bus.err), 4'b0001);
    check("t3_no_done", 32'(bus.done), 0);
    @(negedge clk) bus.req = '0;

    // 5th edge lands on the timeout cycle: done wins.
    gen_pat = 32'h0100_0154;
    @(negedge clk) bus.req = 4'b0010;
    wait_evt(0, 40, "t4_load_wait", c);
    check("t4_grant", 32'(bus.grant), 4'b0010);
    wait_evt(1, 40, "t4_end_wait", c);
    check("t4_latency", 32'(c), 25);
    check("t4_done", 32'(bus.done), 4'b0010);
    check("t4_no_err", 32'(bus.err), 0);
    @(negedge clk) bus.req = '0;

    // Async reset between edges mid-count, then requester 1 from a zero pointer.
    gen_pat = 32'h0000_2AAA;
    @(negedge clk) bus.req = 4'b1000;
    wait_evt(0, 40, "t5_load_wait", c);
    check("t5_grant", 32'(bus.grant), 4'b1000);
    repeat (3) @(posedge clk);
    #3;
    reset   = 1'b0;
    bus.req = '0;
    #1;
    check("t5_rst_grant",    32'(bus.grant),     0);
    check("t5_rst_gen_load", 32'(bus.gen_load),  0);
    check("t5_rst_busy",     32'(bus.busy),      0);
    check("t5_rst_id",       32'(bus.active_id), 0);
    check("t5_rst_done",     32'(bus.done),      0);
    check("t5_rst_err",      32'(bus.err),       0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) bus.req = 4'b0010;
    @(posedge clk); #1;
    check("t5_grant_after", 32'(bus.grant), 4'b0010);
    check("t5_id_after", 32'(bus.active_id), 1);
    wait_evt(1, 40, "t5_end_wait", c);
    check("t5_done", 32'(bus.done), 4'b0010);
    @(negedge clk) bus.req = '0;

    // Owner 2 drops req after two edges; done still arrives, then agent 0 is served.
    gen_pat = 32'h0000_2AAA;
    @(negedge clk) bus.req = 4'b0101;
    wait_evt(0, 40, "t6_load_wait", c);
    check("t6_grant", 32'(bus.grant), 4'b0100);
    repeat (4) @(posedge clk);
    @(negedge clk) bus.req = 4'b0001;
    wait_evt(1, 40, "t6_end_wait", c);
    check("t6_done_latency", 32'(c), 6);
    check("t6_done", 32'(bus.done), 4'b0100);
    wait_evt(0, 40, "t6_load2_wait", c);
    check("t6_next_grant", 32'(bus.grant), 4'b0001);
    wait_evt(1, 40, "t6_end2_wait", c);
    check("t6_done2", 32'(bus.done), 4'b0001);
    @(negedge clk) bus.req = '0;
    repeat (6) @(posedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
